// File: rtl/vx_alu_credit_arb.sv
// Round-robin issue arbiter for the ALU execute port with credit throttling of muldiv ops.
// One-entry registered output stage; muldiv grants consume credits, mdv_done returns them.
module vx_alu_credit_arb #(
    parameter int unsigned NUM_REQS    = 4,
    parameter int unsigned DATAW       = 64,
    parameter int unsigned MAX_CREDITS = 4,
    parameter int unsigned SEL_W       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    parameter int unsigned CNT_W       = $clog2(MAX_CREDITS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS-1:0]       req_muldiv,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      out_valid,
    output logic [DATAW-1:0]          out_data,
    output logic                      out_muldiv,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready,
    input  logic                      mdv_done,
    output logic [CNT_W-1:0]          credit_cnt,
    output logic                      credit_err
);

    logic [DATAW-1:0]    data_arr [NUM_REQS];
    logic [NUM_REQS-1:0] eligible;
    logic [SEL_W:0]      scan_idx;
    logic [SEL_W-1:0]    winner;
    logic                any_elig;
    logic                load;
    logic                dec;
    logic                inc;

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [DATAW-1:0] out_data_q, out_data_d;
    logic             out_muldiv_q, out_muldiv_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic [CNT_W-1:0] credit_q, credit_d;
    logic             err_q, err_d;

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATAW +: DATAW];
    end

    // A muldiv request is only eligible while a credit is available.
    assign eligible = req_valid & (~req_muldiv | {NUM_REQS{credit_q != '0}});

    always_comb begin
        any_elig = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            scan_idx = {1'b0, rr_ptr_q} + (SEL_W+1)'(i);
            if (scan_idx >= (SEL_W+1)'(NUM_REQS)) begin
                scan_idx = scan_idx - (SEL_W+1)'(NUM_REQS);
            end
            if (!any_elig && eligible[scan_idx[SEL_W-1:0]]) begin
                any_elig = 1'b1;
                winner   = scan_idx[SEL_W-1:0];
            end
        end
    end

    assign load = any_elig & (~out_valid_q | out_ready) & ~reset;
    assign dec  = load & req_muldiv[winner];
    assign inc  = mdv_done;

    always_comb begin
        req_ready = '0;
        if (load) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_muldiv_d = out_muldiv_q;
        out_sel_d    = out_sel_q;
        if (load) begin
            out_valid_d  = 1'b1;
            out_data_d   = data_arr[winner];
            out_muldiv_d = req_muldiv[winner];
            out_sel_d    = winner;
            rr_ptr_d     = (winner == SEL_W'(NUM_REQS - 1)) ? '0 : winner + SEL_W'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (dec && !inc) begin
            credit_d = credit_q - CNT_W'(1);
        end else if (inc && !dec) begin
            // An unpaired return at full credit is a protocol error; saturate and flag it.
            if (credit_q == CNT_W'(MAX_CREDITS)) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_muldiv_q <= 1'b0;
            out_sel_q    <= '0;
            credit_q     <= CNT_W'(MAX_CREDITS);
            err_q        <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_muldiv_q <= out_muldiv_d;
            out_sel_q    <= out_sel_d;
            credit_q     <= credit_d;
            err_q        <= err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_muldiv = out_muldiv_q;
    assign out_sel    = out_sel_q;
    assign credit_cnt = credit_q;
    assign credit_err = err_q;

endmodule

// File: doc/vx_alu_credit_arb.md
# vx_alu_credit_arb

Round-robin scheduler that shares one ALU block's execute port among `NUM_REQS` issue requesters and throttles multiply/divide operations with a credit counter. Each muldiv grant consumes one credit, and each muldiv completion returns one, so the muldiv unit never holds more than `MAX_CREDITS` operations in flight. The block sits between per-block dispatch and the int/muldiv split inside the ALU unit. Its output is a one-entry registered pipeline stage.

## Interface
- `NUM_REQS`, default 4: number of requesters; at least 1.
- `DATAW`, default 64: payload width per request.
- `MAX_CREDITS`, default 4: maximum number of outstanding muldiv ops; at least 1.
- `SEL_W` (derived): `` `UP(`CLOG2(NUM_REQS)) ``.
- `CNT_W` (derived): `` `CLOG2(MAX_CREDITS+1) ``.

- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `req_valid` in `NUM_REQS`: per-requester valid.
- `req_muldiv` in `NUM_REQS`: the request is a muldiv op.
- `req_data` in `NUM_REQS*DATAW`: payloads; requester i occupies bits `[i*DATAW +: DATAW]`.
- `req_ready` out `NUM_REQS`: per-requester accept; at most one bit is set.
- `out_valid` out 1: registered output valid.
- `out_data` out `DATAW`: registered payload.
- `out_muldiv` out 1: registered muldiv flag.
- `out_sel` out `SEL_W`: index of the granted requester.
- `out_ready` in 1: downstream accept.
- `mdv_done` in 1: single-cycle pulse, one muldiv op retired; returns one credit.
- `credit_cnt` out `CNT_W`: credits currently available.
- `credit_err` out 1: sticky flag for credit overflow.

## Operation
- **Eligibility.** Requester i is eligible when `req_valid[i]` is high and either `req_muldiv[i]` is low or `credit_cnt` is nonzero.
- **Round-robin search.**
  - Starts at pointer `rr_ptr` and scans upward with wrap.
  - The first eligible index wins.
  - Pure combinational decision from the current inputs and state.
- **Load condition.** `load = any_eligible & (~out_valid | out_ready)`.
  - `req_ready[winner] = load`; all other `req_ready` bits are 0.
  - `req_ready` may depend combinationally on `req_valid`.
- **On load:**
  - Output register captures the winner's data, muldiv flag and index.
  - `out_valid` is set to 1.
  - `rr_ptr` becomes `(winner+1) mod NUM_REQS`.
- **Output drains without refill:** when `out_valid & out_ready & ~load`, `out_valid` goes to 0. Data holds its last value.
- **Pointer hold:** `rr_ptr` changes only on load. Non-eligible (credit-blocked) muldiv requesters are skipped and do not stall other requesters.
- **Credit update, per cycle:**
  - `dec = load & winner_is_muldiv`; `inc = mdv_done`.
  - dec only: `credit_cnt` decrements by 1.
  - inc only: `credit_cnt` increments by 1.
  - Both: count unchanged.
- **Credit overflow.** An `inc` that is not paired with a `dec` while `credit_cnt == MAX_CREDITS`:
  - count saturates at `MAX_CREDITS`;
  - `credit_err` is set to 1 and stays set until reset.
- **Credit underflow** is impossible by construction, because a muldiv request is not eligible at zero credits.
- **`NUM_REQS == 1`:** `rr_ptr` is constant 0 and `out_sel` is 0.

## Timing
- **Reset values:**
  - `out_valid`=0, `out_data`=0, `out_muldiv`=0, `out_sel`=0;
  - `rr_ptr`=0, `credit_cnt`=`MAX_CREDITS`, `credit_err`=0;
  - `req_ready` is all 0 while reset is asserted.
- **Reset mid-operation:** any held output is dropped. Credits return to `MAX_CREDITS` regardless of ops in flight. Downstream is reset together with this block.
- **Latency:** input handshake in cycle N gives `out_valid` in cycle N+1.
- **Throughput:** 1 grant per cycle. A full register with `out_ready`=1 loads and drains in the same cycle.
- **Stall:** `out_valid` & ~`out_ready` means no grant, and `out_data`/`out_sel`/`out_muldiv` hold stable.
- **Credits:** `credit_cnt` reflects updates from the next cycle. A `mdv_done` in cycle N makes a blocked muldiv eligible in cycle N+1, never in cycle N.

## Test plan
1. **Reset.** Reset, then idle → `out_valid`=0, `credit_cnt`=4, `credit_err`=0, `req_ready`=0.
2. **Fairness.** All 4 requesters valid with non-muldiv ops, `out_ready`=1 held → `out_sel` sequence 0,1,2,3,0, one per cycle, first valid 1 cycle after the first grant.
3. **Credit exhaustion.** Requester 2 only, muldiv, `MAX_CREDITS`=4, no `mdv_done` → 4 grants, then `credit_cnt`=0 and `req_ready[2]`=0. Add requester 1 non-muldiv → it is granted while 2 stays blocked. Pulse `mdv_done` → 2 is granted the following cycle.
4. **Backpressure.** `out_ready`=0 with out full and valid payload 0xAB → `out_data` holds 0xAB, `req_ready`=0 every cycle, `rr_ptr` unchanged. Raise `out_ready` → the next winner loads the same cycle.
5. **Simultaneous credit events.** Muldiv grant and `mdv_done` in the same cycle at `credit_cnt`=2 → `credit_cnt` stays 2.
6. **Overflow and mid-run reset.** `mdv_done` at `credit_cnt`=4 → stays 4, `credit_err`=1 and sticky. Assert reset mid-burst → all outputs return to reset values asynchronously.
